// File: rtl/hsv2rgb_if.sv
// Pixel stream bundle for the HSV-to-RGB converter: HSV pixel in, RGB pixel out,
// with the valid/visual/done sideband carried alongside.
interface hsv2rgb_if;
   logic       in_valid;
   logic [7:0] in_hue;
   logic [7:0] in_saturation;
   logic [7:0] in_value;
   logic       in_visual;
   logic       in_done;
   logic       out_valid;
   logic [7:0] out_red;
   logic [7:0] out_green;
   logic [7:0] out_blue;
   logic       out_visual;
   logic       out_done;

   modport master (
      output in_valid, in_hue, in_saturation, in_value, in_visual, in_done,
      input  out_valid, out_red, out_green, out_blue, out_visual, out_done
   );

   modport slave (
      input  in_valid, in_hue, in_saturation, in_value, in_visual, in_done,
      output out_valid, out_red, out_green, out_blue, out_visual, out_done
   );
endinterface

// File: rtl/hsv2rgb.sv
// Streaming HSV-to-RGB converter. One pixel per clock, no backpressure.
// Hue is split into a sector (0..5) and a fraction f, then p/q/t are built
// from truncated 8x8 products and picked per sector. The result registers
// update on the fourth edge after the input is sampled.
module hsv2rgb (
   input logic      clock,
   input logic      reset,
   hsv2rgb_if.slave pix
);
   localparam int DATA_W = 8;

   // Truncating scale: (a*b)>>8, never rounded.
   function automatic logic [DATA_W-1:0] scale_trunc(input logic [DATA_W-1:0] a,
                                                     input logic [DATA_W-1:0] b);
      logic [2*DATA_W-1:0] prod;
      prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      return prod[2*DATA_W-1:DATA_W];
   endfunction

   logic [10:0]       h6;
   logic              vld_p0, vis_p0, done_p0;
   logic [DATA_W-1:0] v_p0, s_p0, f_p0;
   logic [2:0]        sector_p0;
   logic              vld_p1, vis_p1, done_p1;
   logic [DATA_W-1:0] v_p1, sv_p1, sf_p1, sfi_p1;
   logic [2:0]        sector_p1;
   logic              vld_p2, vis_p2, done_p2;
   logic [DATA_W-1:0] v_p2, sv_p2, vsf_p2, vsfi_p2;
   logic [2:0]        sector_p2;
   logic              vld_p3, vis_p3, done_p3;
   logic [DATA_W-1:0] v_p3, p_p3, q_p3, t_p3;
   logic [2:0]        sector_p3;
   logic              vld_p4, vis_p4, done_p4;
   logic [DATA_W-1:0] red_p4, green_p4, blue_p4;

   assign h6 = {3'b000, pix.in_hue} * 11'd6;

   // S1: capture v, s and sideband; split hue*6 into sector and fraction
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p0    <= 1'b0;
         vis_p0    <= 1'b0;
         done_p0   <= 1'b0;
         v_p0      <= '0;
         s_p0      <= '0;
         f_p0      <= '0;
         sector_p0 <= '0;
      end else begin
         vld_p0    <= pix.in_valid;
         vis_p0    <= pix.in_visual;
         done_p0   <= pix.in_done;
         v_p0      <= pix.in_value;
         s_p0      <= pix.in_saturation;
         f_p0      <= h6[7:0];
         sector_p0 <= h6[10:8];
      end
   end

   // S2: saturation-scaled terms sv, sf and s*(255-f)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p1    <= 1'b0;
         vis_p1    <= 1'b0;
         done_p1   <= 1'b0;
         v_p1      <= '0;
         sv_p1     <= '0;
         sf_p1     <= '0;
         sfi_p1    <= '0;
         sector_p1 <= '0;
      end else begin
         vld_p1    <= vld_p0;
         vis_p1    <= vis_p0;
         done_p1   <= done_p0;
         v_p1      <= v_p0;
         sv_p1     <= scale_trunc(v_p0, s_p0);
         sf_p1     <= scale_trunc(s_p0, f_p0);
         sfi_p1    <= scale_trunc(s_p0, ~f_p0);
         sector_p1 <= sector_p0;
      end
   end

   // S3a: value-scaled subtrahends for q and t (multiplier kept apart from the subtract)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p2    <= 1'b0;
         vis_p2    <= 1'b0;
         done_p2   <= 1'b0;
         v_p2      <= '0;
         sv_p2     <= '0;
         vsf_p2    <= '0;
         vsfi_p2   <= '0;
         sector_p2 <= '0;
      end else begin
         vld_p2    <= vld_p1;
         vis_p2    <= vis_p1;
         done_p2   <= done_p1;
         v_p2      <= v_p1;
         sv_p2     <= sv_p1;
         vsf_p2    <= scale_trunc(v_p1, sf_p1);
         vsfi_p2   <= scale_trunc(v_p1, sfi_p1);
         sector_p2 <= sector_p1;
      end
   end

   // S3b: p, q, t; every subtrahend is <= v so these never wrap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p3    <= 1'b0;
         vis_p3    <= 1'b0;
         done_p3   <= 1'b0;
         v_p3      <= '0;
         p_p3      <= '0;
         q_p3      <= '0;
         t_p3      <= '0;
         sector_p3 <= '0;
      end else begin
         vld_p3    <= vld_p2;
         vis_p3    <= vis_p2;
         done_p3   <= done_p2;
         v_p3      <= v_p2;
         p_p3      <= v_p2 - sv_p2;
         q_p3      <= v_p2 - vsf_p2;
         t_p3      <= v_p2 - vsfi_p2;
         sector_p3 <= sector_p2;
      end
   end

   // S4: per-sector component selection; sectors 6/7 cannot occur and fall back to grey
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p4   <= 1'b0;
         vis_p4   <= 1'b0;
         done_p4  <= 1'b0;
         red_p4   <= '0;
         green_p4 <= '0;
         blue_p4  <= '0;
      end else begin
         vld_p4  <= vld_p3;
         vis_p4  <= vis_p3;
         done_p4 <= done_p3;
         case (sector_p3)
            3'd0:    begin red_p4 <= v_p3; green_p4 <= t_p3; blue_p4 <= p_p3; end
            3'd1:    begin red_p4 <= q_p3; green_p4 <= v_p3; blue_p4 <= p_p3; end
            3'd2:    begin red_p4 <= p_p3; green_p4 <= v_p3; blue_p4 <= t_p3; end
            3'd3:    begin red_p4 <= p_p3; green_p4 <= q_p3; blue_p4 <= v_p3; end
            3'd4:    begin red_p4 <= t_p3; green_p4 <= p_p3; blue_p4 <= v_p3; end
            3'd5:    begin red_p4 <= v_p3; green_p4 <= p_p3; blue_p4 <= q_p3; end
            default: begin red_p4 <= v_p3; green_p4 <= v_p3; blue_p4 <= v_p3; end
         endcase
      end
   end

   assign pix.out_valid  = vld_p4;
   assign pix.out_visual = vis_p4;
   assign pix.out_done   = done_p4;
   assign pix.out_red    = red_p4;
   assign pix.out_green  = green_p4;
   assign pix.out_blue   = blue_p4;
endmodule

// File: tb/tb_hsv2rgb.sv
// Bench for hsv2rgb: integer reference conversion, a 4-edge expectation delay
// line, a per-cycle output compare, and literal pixel checks.
module tb_hsv2rgb;
   logic clock = 1'b0;
   logic reset = 1'b0;

   always #5 clock = ~clock;

   hsv2rgb_if bus ();

   hsv2rgb dut (
      .clock (clock),
      .reset (reset),
      .pix   (bus)
   );

   typedef struct packed {
      logic       vld;
      logic       vis;
      logic       dn;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   exp_t hist [1:5];
   int   checks   = 0;
   int   failures = 0;

   // Reference conversion straight from the sector/p/q/t rules with integer math
   function automatic exp_t model(input logic vld, input logic vis, input logic dn,
                                  input int hue, input int sat, input int val);
      int   h6, sector, f, sv, sf, sfi, p, q, t, r, g, b;
      exp_t e;
      h6     = hue * 6;
      sector = h6 / 256;
      f      = h6 % 256;
      sv     = (val * sat) / 256;
      sf     = (sat * f) / 256;
      sfi    = (sat * (255 - f)) / 256;
      p      = val - sv;
      q      = val - (val * sf) / 256;
      t      = val - (val * sfi) / 256;
      case (sector)
         0:       begin r = val; g = t;   b = p;   end
         1:       begin r = q;   g = val; b = p;   end
         2:       begin r = p;   g = val; b = t;   end
         3:       begin r = p;   g = q;   b = val; end
         4:       begin r = t;   g = p;   b = val; end
         5:       begin r = val; g = p;   b = q;   end
         default: begin r = val; g = val; b = val; end
      endcase
      e.vld = vld;
      e.vis = vis;
      e.dn  = dn;
      e.r   = 8'(r);
      e.g   = 8'(g);
      e.b   = 8'(b);
      return e;
   endfunction

   // Expected output stream: what was sampled four edges before the current one
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= 5; i++) hist[i] <= '0;
      end else begin
         hist[1] <= model(bus.in_valid, bus.in_visual, bus.in_done,
                          int'(bus.in_hue), int'(bus.in_saturation), int'(bus.in_value));
         for (int i = 2; i <= 5; i++) hist[i] <= hist[i-1];
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic cmp_outputs();
      exp_t e;
      e = hist[5];
      chk("out_valid", {7'd0, bus.out_valid}, {7'd0, e.vld});
      chk("out_visual", {7'd0, bus.out_visual}, {7'd0, e.vis});
      chk("out_done", {7'd0, bus.out_done}, {7'd0, e.dn});
      if (e.vld || reset) begin
         chk("out_red", bus.out_red, e.r);
         chk("out_green", bus.out_green, e.g);
         chk("out_blue", bus.out_blue, e.b);
      end
   endtask

   // Present one input for one edge, then compare outputs at the following negedge
   task automatic drive(input logic v, input logic vis, input logic dn,
                        input logic [7:0] h, input logic [7:0] s, input logic [7:0] val);
      bus.in_valid      = v;
      bus.in_visual     = vis;
      bus.in_done       = dn;
      bus.in_hue        = h;
      bus.in_saturation = s;
      bus.in_value      = val;
      @(negedge clock);
      cmp_outputs();
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic all_zero(input string tag);
      chk({tag, "_valid"}, {7'd0, bus.out_valid}, 8'd0);
      chk({tag, "_visual"}, {7'd0, bus.out_visual}, 8'd0);
      chk({tag, "_done"}, {7'd0, bus.out_done}, 8'd0);
      chk({tag, "_red"}, bus.out_red, 8'd0);
      chk({tag, "_green"}, bus.out_green, 8'd0);
      chk({tag, "_blue"}, bus.out_blue, 8'd0);
   endtask

   // Single pixel with hand-computed RGB: pins both the DUT and the model
   task automatic lit_pixel(input string tag, input logic [7:0] h, input logic [7:0] s,
                            input logic [7:0] val, input logic [7:0] er,
                            input logic [7:0] eg, input logic [7:0] eb);
      exp_t m;
      m = model(1'b1, 1'b0, 1'b0, int'(h), int'(s), int'(val));
      chk({tag, "_model_r"}, m.r, er);
      chk({tag, "_model_g"}, m.g, eg);
      chk({tag, "_model_b"}, m.b, eb);
      drive(1'b1, 1'b0, 1'b0, h, s, val);
      repeat (4) idle();
      chk({tag, "_valid"}, {7'd0, bus.out_valid}, 8'd1);
      chk({tag, "_red"}, bus.out_red, er);
      chk({tag, "_green"}, bus.out_green, eg);
      chk({tag, "_blue"}, bus.out_blue, eb);
   endtask

   initial begin
      bus.in_valid      = 1'b0;
      bus.in_visual     = 1'b0;
      bus.in_done       = 1'b0;
      bus.in_hue        = 8'd0;
      bus.in_saturation = 8'd0;
      bus.in_value      = 8'd0;
      #1 reset = 1'b1;
      #1 all_zero("reset_state");
      repeat (2) @(negedge clock);
      reset = 1'b0;

      lit_pixel("red_primary", 8'd0, 8'd255, 8'd255, 8'd255, 8'd2, 8'd1);
      lit_pixel("green_primary", 8'd85, 8'd255, 8'd255, 8'd3, 8'd255, 8'd1);
      lit_pixel("cyan", 8'd128, 8'd255, 8'd200, 8'd1, 8'd200, 8'd200);
      lit_pixel("grey", 8'd77, 8'd0, 8'd100, 8'd100, 8'd100, 8'd100);
      lit_pixel("black", 8'd200, 8'd180, 8'd0, 8'd0, 8'd0, 8'd0);
      lit_pixel("sector5", 8'd250, 8'd255, 8'd255, 8'd255, 8'd1, 8'd37);

      // 10 valid, 3-cycle bubble, 5 valid; visual toggles, done on frame ends
      for (int i = 0; i < 18; i++) begin
         drive(!(i >= 10 && i < 13), (i % 2) == 1, (i == 9) || (i == 17),
               8'(i * 37 + 5), 8'(255 - i * 13), 8'(40 + i * 12));
      end
      repeat (5) idle();

      // Reset between edges with output valid and pixels still in flight
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(i * 40), 8'd200, 8'd180);
      end
      #2 reset = 1'b1;
      #1 all_zero("reset_mid");
      @(negedge clock);
      cmp_outputs();
      reset = 1'b0;
      lit_pixel("after_reset", 8'd85, 8'd255, 8'd255, 8'd3, 8'd255, 8'd1);
      repeat (2) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
